// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, INIT sweep FSM, registered mispredict flag.
// Optional BPU_STATS_EN adds saturating update/mispredict counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc_f,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  output logic            o_ready,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_pred_taken,
  input  logic [XLEN-1:0] i_upd_pred_target,
  output logic            o_mispredict,
  output logic [31:0]     o_stat_updates,
  output logic [31:0]     o_stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  tgt;
    logic [1:0]       ctr;
  } entry_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
  entry_t [ENTRIES-1:0] r_tbl;
  logic                 r_mis;

  // FSM: sweep one entry per cycle, flush restarts the sweep from entry 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (i_flush) begin
      w_state_nxt = S_INIT;
      w_ptr_nxt   = '0;
    end else if (r_state == S_INIT) begin
      w_ptr_nxt = r_ptr + 1'b1;
      if (r_ptr == IDX_W'(ENTRIES-1)) w_state_nxt = S_RUN;
    end
  end

  assign o_ready = (r_state == S_RUN);

  // Fetch lookup reads the registered table, so a same-cycle update is not visible
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  entry_t           w_f_ent;
  logic             w_f_hit;

  assign w_f_idx       = i_pc_f[IDX_W+1:2];
  assign w_f_tag       = i_pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign w_f_ent       = r_tbl[w_f_idx];
  assign w_f_hit       = w_f_ent.vld && (w_f_ent.tag == w_f_tag);
  assign o_pred_taken  = o_ready && w_f_hit && w_f_ent.ctr[1];
  assign o_pred_target = o_pred_taken ? w_f_ent.tgt : i_pc_f + XLEN'(4);

  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  entry_t           w_u_ent;
  logic             w_u_hit;
  logic             w_u_en;
  logic             w_unused;

  assign w_u_idx  = i_upd_pc[IDX_W+1:2];
  assign w_u_tag  = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_u_ent  = r_tbl[w_u_idx];
  assign w_u_hit  = w_u_ent.vld && (w_u_ent.tag == w_u_tag);
  assign w_u_en   = i_upd_valid && (r_state == S_RUN) && !i_flush && !i_rst;
  assign w_unused = ^i_upd_pc;

  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == S_INIT) begin
      r_tbl[r_ptr].vld <= 1'b0;
      r_tbl[r_ptr].ctr <= 2'b01;
    end else if (w_u_en) begin
      if (w_u_hit) begin
        if (i_upd_taken) begin
          if (w_u_ent.ctr != 2'b11) r_tbl[w_u_idx].ctr <= w_u_ent.ctr + 2'b01;
          r_tbl[w_u_idx].tgt <= i_upd_target;
        end else if (w_u_ent.ctr != 2'b00) begin
          r_tbl[w_u_idx].ctr <= w_u_ent.ctr - 2'b01;
        end
      end else if (i_upd_taken) begin
        r_tbl[w_u_idx] <= '{vld: 1'b1, tag: w_u_tag, tgt: i_upd_target, ctr: 2'b10};
      end
    end
  end

  // Mispredict tracks the branch unit every cycle, independent of table state
  logic w_mis;
  assign w_mis = i_upd_valid && ((i_upd_pred_taken != i_upd_taken) ||
                 (i_upd_taken && (i_upd_pred_target != i_upd_target)));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_mis <= 1'b0;
    else       r_mis <= w_mis;
  end

  assign o_mispredict = r_mis;

`ifdef BPU_STATS_EN
  logic [31:0] r_stat_upd, r_stat_mis;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else begin
      if (i_upd_valid && r_stat_upd != '1) r_stat_upd <= r_stat_upd + 32'd1;
      if (w_mis && r_stat_mis != '1)       r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign o_stat_updates     = r_stat_upd;
  assign o_stat_mispredicts = r_stat_mis;
`else
  assign o_stat_updates     = '0;
  assign o_stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;

  logic            i_clk = 1'b0;
  logic            i_rst, i_flush;
  logic [XLEN-1:0] i_pc_f;
  logic            o_pred_taken;
  logic [XLEN-1:0] o_pred_target;
  logic            o_ready;
  logic            i_upd_valid, i_upd_taken, i_upd_pred_taken;
  logic [XLEN-1:0] i_upd_pc, i_upd_target, i_upd_pred_target;
  logic            o_mispredict;
  logic [31:0]     o_stat_updates, o_stat_mispredicts;

  int n_chk  = 0;
  int n_fail = 0;
  int e_upd  = 0;
  int e_mis  = 0;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_pc_f(i_pc_f),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target), .o_ready(o_ready),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_target(i_upd_target), .i_upd_pred_taken(i_upd_pred_taken),
    .i_upd_pred_target(i_upd_pred_target), .o_mispredict(o_mispredict),
    .o_stat_updates(o_stat_updates), .o_stat_mispredicts(o_stat_mispredicts)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // One-cycle update; exp_mis is the hand-computed mispredict condition
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt, input int exp_mis);
    i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_taken = tk; i_upd_target = tgt;
    i_upd_pred_taken = ptk; i_upd_pred_target = ptgt;
    step();
    i_upd_valid = 1'b0;
    e_upd++;
    e_mis += exp_mis;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_pc_f = '0; i_upd_valid = 1'b0; i_upd_pc = '0;
    i_upd_taken = 1'b0; i_upd_target = '0; i_upd_pred_taken = 1'b0; i_upd_pred_target = '0;
    step(); step();
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", o_ready); end
    n_chk++; if (o_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %b exp 0", o_mispredict); end
    n_chk++; if (o_stat_updates !== 32'd0 || o_stat_mispredicts !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats got %0d/%0d exp 0/0", o_stat_updates, o_stat_mispredicts); end
    i_rst = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      i_pc_f = 32'h1000 + 32'(i * 4);
      #1;
      n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready cyc %0d got %b exp 0", i, o_ready); end
      n_chk++; if (o_pred_taken !== 1'b0 || o_pred_target !== i_pc_f + 32'd4) begin
        n_fail++; $display("FAIL init_pred cyc %0d got %b/%h exp 0/%h", i, o_pred_taken, o_pred_target, i_pc_f + 32'd4); end
      step();
    end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ready_rise got %b exp 1", o_ready); end
  endtask

  task automatic test_alloc();
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1);
    n_chk++; if (o_mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mis got %b exp 1", o_mispredict); end
    i_pc_f = 32'h100; #1;
    n_chk++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h200) begin
      n_fail++; $display("FAIL alloc_hit got %b/%h exp 1/200", o_pred_taken, o_pred_target); end
    i_pc_f = 32'h104; #1;
    n_chk++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h108) begin
      n_fail++; $display("FAIL alloc_neighbour got %b/%h exp 0/108", o_pred_taken, o_pred_target); end
  endtask

  task automatic test_train();
    i_pc_f = 32'h100;
    upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 0);  // ctr 11
    upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 0);  // stays 11
    upd(32'h100, 1'b1, 32'h240, 1'b1, 32'h200, 1);  // target moves
    upd(32'h100, 1'b1, 32'h240, 1'b1, 32'h240, 0);
    #1;
    n_chk++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h240) begin
      n_fail++; $display("FAIL train_strong got %b/%h exp 1/240", o_pred_taken, o_pred_target); end
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h240, 1);    // 10
    #1;
    n_chk++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h240) begin
      n_fail++; $display("FAIL train_sat_hi got %b/%h exp 1/240", o_pred_taken, o_pred_target); end
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h240, 1);    // 01
    #1;
    n_chk++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) begin
      n_fail++; $display("FAIL train_weak_nt got %b/%h exp 0/104", o_pred_taken, o_pred_target); end
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 0);      // 00
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 0);      // stays 00
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1);    // 01
    #1;
    n_chk++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) begin
      n_fail++; $display("FAIL train_sat_lo got %b/%h exp 0/104", o_pred_taken, o_pred_target); end
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1);    // 10
    #1;
    n_chk++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h200) begin
      n_fail++; $display("FAIL train_retake got %b/%h exp 1/200", o_pred_taken, o_pred_target); end
  endtask

  task automatic test_alias();
    i_pc_f = 32'h100;
    i_upd_valid = 1'b1; i_upd_pc = 32'h140; i_upd_taken = 1'b1; i_upd_target = 32'h380;
    i_upd_pred_taken = 1'b0; i_upd_pred_target = 32'h0;
    #1;
    n_chk++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h200) begin
      n_fail++; $display("FAIL read_before_write got %b/%h exp 1/200", o_pred_taken, o_pred_target); end
    step();
    i_upd_valid = 1'b0; e_upd++; e_mis++;
    #1;
    n_chk++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) begin
      n_fail++; $display("FAIL alias_evict got %b/%h exp 0/104", o_pred_taken, o_pred_target); end
    i_pc_f = 32'h140; #1;
    n_chk++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h380) begin
      n_fail++; $display("FAIL alias_new got %b/%h exp 1/380", o_pred_taken, o_pred_target); end
  endtask

  task automatic test_mispredict();
    upd(32'h500, 1'b1, 32'h300, 1'b1, 32'h200, 1);
    n_chk++; if (o_mispredict !== 1'b1) begin n_fail++; $display("FAIL mis_target got %b exp 1", o_mispredict); end
    step();
    n_chk++; if (o_mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got %b exp 0", o_mispredict); end
    upd(32'h600, 1'b1, 32'h300, 1'b1, 32'h300, 0);
    n_chk++; if (o_mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_match got %b exp 0", o_mispredict); end
    upd(32'h604, 1'b0, 32'h222, 1'b0, 32'h111, 0);
    n_chk++; if (o_mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_nt_tgt got %b exp 0", o_mispredict); end
    upd(32'h608, 1'b0, 32'h0, 1'b1, 32'h0, 1);
    n_chk++; if (o_mispredict !== 1'b1) begin n_fail++; $display("FAIL mis_dir got %b exp 1", o_mispredict); end
  endtask

  task automatic test_flush();
    logic [31:0] exp_u, exp_m;
    i_pc_f = 32'h600; #1;
    n_chk++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h300) begin
      n_fail++; $display("FAIL pre_flush got %b/%h exp 1/300", o_pred_taken, o_pred_target); end
    i_flush = 1'b1;
    upd(32'h180, 1'b1, 32'h400, 1'b0, 32'h0, 1);
    i_flush = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready cyc %0d got %b exp 0", i, o_ready); end
      if (i == 3) upd(32'h1C0, 1'b1, 32'h500, 1'b0, 32'h0, 1);
      else step();
    end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_rise got %b exp 1", o_ready); end
    for (int i = 0; i < 3; i++) begin
      i_pc_f = (i == 0) ? 32'h600 : (i == 1) ? 32'h180 : 32'h1C0;
      #1;
      n_chk++; if (o_pred_taken !== 1'b0 || o_pred_target !== i_pc_f + 32'd4) begin
        n_fail++; $display("FAIL flush_miss pc %h got %b/%h exp 0/%h", i_pc_f, o_pred_taken, o_pred_target, i_pc_f + 32'd4); end
    end
`ifdef BPU_STATS_EN
    exp_u = 32'(e_upd); exp_m = 32'(e_mis);
`else
    exp_u = 32'd0; exp_m = 32'd0;
`endif
    n_chk++; if (o_stat_updates !== exp_u) begin n_fail++; $display("FAIL stat_updates got %0d exp %0d", o_stat_updates, exp_u); end
    n_chk++; if (o_stat_mispredicts !== exp_m) begin n_fail++; $display("FAIL stat_mis got %0d exp %0d", o_stat_mispredicts, exp_m); end
  endtask

  task automatic test_flush_in_init();
    i_flush = 1'b1; step(); i_flush = 1'b0;
    for (int i = 0; i < 5; i++) step();
    i_flush = 1'b1; step(); i_flush = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reflush_ready cyc %0d got %b exp 0", i, o_ready); end
      step();
    end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reflush_rise got %b exp 1", o_ready); end
  endtask

  task automatic test_rst_clears();
    i_upd_valid = 1'b1; i_upd_pc = 32'h100; i_upd_taken = 1'b1; i_upd_target = 32'h900;
    i_upd_pred_taken = 1'b0; i_flush = 1'b1; i_rst = 1'b1;
    step();
    i_upd_valid = 1'b0; i_flush = 1'b0; i_rst = 1'b0;
    n_chk++; if (o_mispredict !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_prio got mis %b rdy %b exp 0/0", o_mispredict, o_ready); end
    n_chk++; if (o_stat_updates !== 32'd0 || o_stat_mispredicts !== 32'd0) begin
      n_fail++; $display("FAIL rst_stats got %0d/%0d exp 0/0", o_stat_updates, o_stat_mispredicts); end
    for (int i = 0; i < ENTRIES; i++) step();
    i_pc_f = 32'h100; #1;
    n_chk++; if (o_ready !== 1'b1 || o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) begin
      n_fail++; $display("FAIL rst_table got rdy %b pred %b/%h exp 1 0/104", o_ready, o_pred_taken, o_pred_target); end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_alloc();
    test_train();
    test_alias();
    test_mispredict();
    test_flush();
    test_flush_in_init();
    test_rst_clears();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
